// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared types and helpers for pipe_adder
//
// Purpose: operation-mode encoding and chunk-width derivation used by
//          pipe_adder and pipe_adder_stage.
// Ports:   none (package).

package pipe_adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_mode_e;

   // Bits of the carry chain resolved by each pipeline stage.
   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic bit params_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// rtl/pipe_adder_stage.sv - one carry-chunk stage of the pipelined adder
//
// Purpose: resolves chunk IDX of the sum, registers the chunk carry and
//          forwards the operands and partial result one stage downstream.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid            upstream beat valid
//   out_ready           downstream stage (or consumer) can take a beat
//   in_a / in_b         A word (partial result + unconsumed A chunks), B word
//   in_carry            carry into chunk IDX
//   out_valid           this stage holds a beat
//   out_a / out_b       registered A word (chunk IDX now holds the sum), B word
//   out_carry           registered carry out of chunk IDX

module pipe_adder_stage
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CW    = 8,
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             out_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_carry,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             out_carry
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic             load;
   logic [CW:0]      chunk_sum;

   // The partial result shares the A word: chunks below IDX already hold
   // sum bits, chunks above IDX still hold unconsumed A operand bits.
   always_comb begin
      load      = in_valid && (!valid_q || out_ready);
      chunk_sum = {1'b0, in_a[IDX*CW +: CW]} + {1'b0, in_b[IDX*CW +: CW]}
                + {{CW{1'b0}}, in_carry};
      valid_d   = valid_q;
      a_d       = a_q;
      b_d       = b_q;
      carry_d   = carry_q;
      if (load) begin
         valid_d                = 1'b1;
         a_d                    = in_a;
         a_d[IDX*CW +: CW]      = chunk_sum[CW-1:0];
         b_d                    = in_b;
         carry_d                = chunk_sum[CW];
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
      end
   end

   assign out_valid = valid_q;
   assign out_a     = a_q;
   assign out_b     = b_q;
   assign out_carry = carry_q;

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined WIDTH-bit add/subtract with valid/ready
//
// Purpose: WIDTH-bit adder/subtractor whose carry chain is split into STAGES
//          chunks, one chunk resolved per pipeline stage.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   io_in_valid / io_in_ready    operand handshake
//   io_lhs, io_rhs               operands
//   io_cin                       carry-in (add) / borrow-in (sub)
//   io_sub                       0 = add, 1 = subtract
//   io_out_valid / io_out_ready  result handshake
//   io_out, io_cout              result and carry-out (sub: 1 = no borrow)

module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_lhs,
   input  logic [WIDTH-1:0] io_rhs,
   input  logic             io_cin,
   input  logic             io_sub,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out,
   output logic             io_cout
);

   localparam int CW = chunk_width(WIDTH, STAGES);

   if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
      $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
   end

   op_mode_e         mode;
   logic [STAGES:0]  valid_c;
   logic [STAGES:0]  ready_c;
   logic [WIDTH-1:0] a_c     [0:STAGES];
   logic [WIDTH-1:0] b_c     [0:STAGES];
   logic             carry_c [0:STAGES];

   // Subtraction is folded in once at acceptance (A + ~B + ~borrow), so
   // every stage is a plain adder.
   assign mode       = op_mode_e'(io_sub);
   assign valid_c[0] = io_in_valid;
   assign a_c[0]     = io_lhs;
   assign b_c[0]     = (mode == OP_SUB) ? ~io_rhs : io_rhs;
   assign carry_c[0] = (mode == OP_SUB) ? ~io_cin : io_cin;

   // Ready ripples back from the consumer so a full pipe can accept and
   // drain in the same cycle; it depends only on stage valids.
   always_comb begin
      ready_c         = '0;
      ready_c[STAGES] = io_out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         ready_c[k] = !valid_c[k+1] || ready_c[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_adder_stage #(
         .WIDTH (WIDTH),
         .CW    (CW),
         .IDX   (k)
      ) u_stage (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (valid_c[k]),
         .out_ready (ready_c[k+1]),
         .in_a      (a_c[k]),
         .in_b      (b_c[k]),
         .in_carry  (carry_c[k]),
         .out_valid (valid_c[k+1]),
         .out_a     (a_c[k+1]),
         .out_b     (b_c[k+1]),
         .out_carry (carry_c[k+1])
      );
   end

   assign io_in_ready  = ready_c[0];
   assign io_out_valid = valid_c[STAGES];
   assign io_out       = a_c[STAGES];
   assign io_cout      = carry_c[STAGES];

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - directed and golden-model checks for pipe_adder

module tb_pipe_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // u_a: WIDTH=8, STAGES=2
   logic       a_iv = 0, a_ir, a_ov, a_or = 0, a_cin = 0, a_sub = 0, a_cout;
   logic [7:0] a_lhs = 0, a_rhs = 0, a_out;
   // u_b: WIDTH=32, STAGES=4
   logic        b_iv = 0, b_ir, b_ov, b_or = 0, b_cin = 0, b_sub = 0, b_cout;
   logic [31:0] b_lhs = 0, b_rhs = 0, b_out;
   // u_c: WIDTH=16, STAGES=4
   logic        c_iv = 0, c_ir, c_ov, c_or = 0, c_cin = 0, c_sub = 0, c_cout;
   logic [15:0] c_lhs = 0, c_rhs = 0, c_out;

   pipe_adder #(.WIDTH(8), .STAGES(2)) u_a (
      .clk(clk), .reset(rst), .io_in_valid(a_iv), .io_in_ready(a_ir),
      .io_lhs(a_lhs), .io_rhs(a_rhs), .io_cin(a_cin), .io_sub(a_sub),
      .io_out_valid(a_ov), .io_out_ready(a_or), .io_out(a_out), .io_cout(a_cout));

   pipe_adder #(.WIDTH(32), .STAGES(4)) u_b (
      .clk(clk), .reset(rst), .io_in_valid(b_iv), .io_in_ready(b_ir),
      .io_lhs(b_lhs), .io_rhs(b_rhs), .io_cin(b_cin), .io_sub(b_sub),
      .io_out_valid(b_ov), .io_out_ready(b_or), .io_out(b_out), .io_cout(b_cout));

   pipe_adder #(.WIDTH(16), .STAGES(4)) u_c (
      .clk(clk), .reset(rst), .io_in_valid(c_iv), .io_in_ready(c_ir),
      .io_lhs(c_lhs), .io_rhs(c_rhs), .io_cin(c_cin), .io_sub(c_sub),
      .io_out_valid(c_ov), .io_out_ready(c_or), .io_out(c_out), .io_cout(c_cout));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_tests++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid: got %b exp 0", a_ov); end
      n_tests++; if (a_out !== 8'h00 || a_cout !== 1'b0) begin n_fail++; $display("FAIL reset_a_data: got %h/%b exp 00/0", a_out, a_cout); end
      n_tests++; if (b_ov !== 1'b0 || c_ov !== 1'b0) begin n_fail++; $display("FAIL reset_bc_valid: got %b%b exp 00", b_ov, c_ov); end
      rst = 1'b0;
      #1;
      n_tests++; if ({a_ir, b_ir, c_ir} !== 3'b111) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 111", {a_ir, b_ir, c_ir}); end
   endtask

   task automatic test_carry();
      a_or = 1; a_lhs = 8'hFF; a_rhs = 8'h01; a_cin = 0; a_sub = 0; a_iv = 1;
      tick();
      a_iv = 0;
      n_tests++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL carry_early: got valid %b exp 0", a_ov); end
      tick();
      n_tests++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL carry_latency: got valid %b exp 1", a_ov); end
      n_tests++; if (a_out !== 8'h00 || a_cout !== 1'b1) begin n_fail++; $display("FAIL carry_result: got %h/%b exp 00/1", a_out, a_cout); end
      tick();
      n_tests++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL carry_drained: got valid %b exp 0", a_ov); end
   endtask

   task automatic test_sub();
      a_or = 1; a_sub = 1; a_lhs = 8'h05; a_rhs = 8'h07; a_cin = 0; a_iv = 1;
      tick();
      a_lhs = 8'h07; a_rhs = 8'h05; a_cin = 1;
      tick();
      a_iv = 0;
      n_tests++; if (a_ov !== 1'b1 || a_out !== 8'hFE || a_cout !== 1'b0) begin n_fail++; $display("FAIL sub_borrow: got %b %h/%b exp 1 FE/0", a_ov, a_out, a_cout); end
      tick();
      n_tests++; if (a_ov !== 1'b1 || a_out !== 8'h01 || a_cout !== 1'b1) begin n_fail++; $display("FAIL sub_noborrow: got %b %h/%b exp 1 01/1", a_ov, a_out, a_cout); end
      tick();
      a_sub = 0;
   endtask

   task automatic test_back_to_back();
      int first = -1;
      int last  = -1;
      int cnt   = 0;
      b_or = 1; b_sub = 0; b_cin = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
         if (cyc < 8) begin
            b_iv = 1; b_lhs = 32'(cyc) + 32'h10; b_rhs = 32'hFFFF_FFF0;
            #1;
            n_tests++; if (b_ir !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: cyc %0d got %b exp 1", cyc, b_ir); end
         end else begin
            b_iv = 0;
         end
         tick();
         if (b_ov === 1'b1) begin
            if (first < 0) first = cyc;
            last = cyc;
            n_tests++; if (b_out !== 32'(cnt) || b_cout !== 1'b1) begin n_fail++; $display("FAIL b2b_result: got %h/%b exp %h/1", b_out, b_cout, 32'(cnt)); end
            cnt++;
         end
      end
      n_tests++; if (cnt !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d exp 8", cnt); end
      n_tests++; if (first !== 3 || last !== 10) begin n_fail++; $display("FAIL b2b_window: got %0d..%0d exp 3..10", first, last); end
   endtask

   task automatic test_backpressure();
      a_or = 0; a_sub = 0; a_cin = 0;
      a_lhs = 8'h10; a_rhs = 8'h20; a_iv = 1;
      #1;
      n_tests++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL bp_accept1: got %b exp 1", a_ir); end
      tick();
      a_lhs = 8'hF0; a_rhs = 8'h20;
      #1;
      n_tests++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL bp_accept2: got %b exp 1", a_ir); end
      tick();
      a_lhs = 8'h03; a_rhs = 8'h01; a_sub = 1;
      #1;
      n_tests++; if (a_ir !== 1'b0) begin n_fail++; $display("FAIL bp_full: got in_ready %b exp 0", a_ir); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (a_ov !== 1'b1 || a_out !== 8'h30 || a_cout !== 1'b0 || a_ir !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold: cycle %0d got v%b %h/%b rdy%b exp v1 30/0 rdy0", i, a_ov, a_out, a_cout, a_ir);
         end
      end
      a_or = 1;
      #1;
      n_tests++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b exp 1", a_ir); end
      tick();
      a_iv = 0;
      n_tests++; if (a_ov !== 1'b1 || a_out !== 8'h10 || a_cout !== 1'b1) begin n_fail++; $display("FAIL bp_second: got %b %h/%b exp 1 10/1", a_ov, a_out, a_cout); end
      tick();
      n_tests++; if (a_ov !== 1'b1 || a_out !== 8'h02 || a_cout !== 1'b1) begin n_fail++; $display("FAIL bp_third: got %b %h/%b exp 1 02/1", a_ov, a_out, a_cout); end
      tick();
      a_sub = 0;
      n_tests++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got valid %b exp 0", a_ov); end
   endtask

   task automatic test_reset_midflight();
      a_or = 1; a_sub = 0; a_cin = 0;
      a_lhs = 8'h11; a_rhs = 8'h22; a_iv = 1;
      tick();
      a_lhs = 8'h01; a_rhs = 8'h01;
      tick();
      a_iv = 0;
      n_tests++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL rst_inflight: got valid %b exp 1", a_ov); end
      #2;
      rst = 1'b1;
      #1;
      n_tests++; if (a_ov !== 1'b0 || a_out !== 8'h00 || a_cout !== 1'b0) begin n_fail++; $display("FAIL rst_async: got %b %h/%b exp 0 00/0", a_ov, a_out, a_cout); end
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_tests++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", a_ir); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rst_ghost: cycle %0d got valid %b exp 0", i, a_ov); end
      end
      a_lhs = 8'h40; a_rhs = 8'h02; a_cin = 1; a_iv = 1;
      tick();
      a_iv = 0; a_cin = 0;
      tick();
      n_tests++; if (a_ov !== 1'b1 || a_out !== 8'h43 || a_cout !== 1'b0) begin n_fail++; $display("FAIL rst_newbeat: got %b %h/%b exp 1 43/0", a_ov, a_out, a_cout); end
   endtask

   task automatic test_random();
      logic [16:0] exp_q[$];
      logic [16:0] e;
      int d;
      for (int cyc = 0; cyc < 640; cyc++) begin
         if (cyc < 600) begin
            c_iv  = ($urandom_range(0, 3) != 0);
            c_or  = ($urandom_range(0, 3) != 0);
            c_lhs = 16'($urandom);
            c_rhs = 16'($urandom);
            c_cin = 1'($urandom);
            c_sub = 1'($urandom);
         end else begin
            c_iv = 0;
            c_or = 1;
         end
         #1;
         if (c_ov === 1'b1 && c_or === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rand_extra: got %h/%b exp no beat", c_out, c_cout);
            end else begin
               e = exp_q.pop_front();
               if ({c_cout, c_out} !== e) begin n_fail++; $display("FAIL rand_result: got %h/%b exp %h/%b", c_out, c_cout, e[15:0], e[16]); end
            end
         end
         if (c_iv === 1'b1 && c_ir === 1'b1) begin
            if (c_sub) begin
               d = int'(c_lhs) - int'(c_rhs) - int'(c_cin);
               e = {(d >= 0), d[15:0]};
            end else begin
               d = int'(c_lhs) + int'(c_rhs) + int'(c_cin);
               e = {d[16], d[15:0]};
            end
            exp_q.push_back(e);
         end
         tick();
      end
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_dropped: got %0d beats left exp 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_carry();
      test_sub();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
Parametrised, pipelined successor to the team's 2-bit combinational carry adder. It computes a WIDTH-bit add or subtract with carry/borrow-in and carry-out. The carry chain is split into STAGES equal chunks, with one chunk resolved per pipeline stage, so wide adders close timing. It sits between producer and consumer datapath blocks behind a valid/ready handshake, sustaining one operation per cycle under full backpressure support.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages (1..WIDTH); chunk width CW = WIDTH/STAGES.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
io_in_valid  input  1  operand beat valid.
io_in_ready  output  1  adder can accept a beat this cycle.
io_lhs  input  WIDTH  left operand.
io_rhs  input  WIDTH  right operand.
io_cin  input  1  carry-in (add) / borrow-in (sub).
io_sub  input  1  0 = add, 1 = subtract.
io_out_valid  output  1  result beat valid.
io_out_ready  input  1  consumer accepts result.
io_out  output  WIDTH  result.
io_cout  output  1  carry-out of the full WIDTH-bit sum.

Behaviour:
- Arithmetic, mod 2^WIDTH:
  - add: {io_cout, io_out} = lhs + rhs + cin.
  - sub: operand B = ~rhs, carry-in = ~cin, i.e. lhs - rhs - cin.
  - In sub mode io_cout = 1 means no borrow.
  - Operand inversion happens at acceptance; downstream stages are mode-agnostic.
- Stage k (0..STAGES-1):
  - holds valid_k, the partial result for chunks 0..k, the carry out of chunk k, and the unconsumed operand chunks k+1..STAGES-1.
  - on load, stage k adds chunk k of A and B plus the incoming carry (from io_cin-derived carry for k=0, else the registered carry of stage k-1), CW+1 bits wide.
- Last stage drives io_out, io_cout and io_out_valid directly from registers; no combinational input-to-output path for data.
- Handshake per stage:
  - advance_k = valid_k && ready_{k+1}; ready_k = !valid_k || advance_k.
  - The last stage uses io_out_ready; io_in_ready = ready_0.
  - Transfers occur only when valid && ready are both high at a rising edge.
- Latency: a beat accepted at edge n is presented on io_out_valid after edge n+STAGES-1. That is STAGES cycles from the io_in_valid cycle when unstalled.
- Throughput: one beat per cycle while io_out_ready = 1; no bubbles inserted.
- Backpressure:
  - With io_out_ready = 0, the pipeline fills up to STAGES beats, then io_in_ready = 0.
  - io_out and io_cout must stay stable while io_out_valid && !io_out_ready.
  - Order is strictly FIFO.
- Simultaneous accept and drain when full: allowed. The ready chain passes combinationally from io_out_ready to io_in_ready.
- io_lhs/io_rhs/io_cin/io_sub are don't-care when io_in_valid = 0.
- Reset:
  - Asynchronous: all valid_k cleared immediately; io_out_valid = 0, io_out = 0, io_cout = 0.
  - io_in_ready = 1 in the first cycle after reset deasserts.
  - In-flight beats are discarded (reset mid-operation loses them; no partial output).
- STAGES = 1: single registered adder, latency 1.

Decomposition:
- Shared package:
  - CW = WIDTH/STAGES derived constant.
  - elaboration check WIDTH % STAGES == 0 (error otherwise).
  - op-mode encoding ADD = 0, SUB = 1.
- Sub-module pipe_adder_stage (parametrised by CW, index, remaining width):
  - chunk add, carry register, operand/result shift registers, valid/ready logic.
  - Top level instantiates STAGES copies in a generate loop and handles sub-mode inversion.

Test Plan:
1. WIDTH=8, STAGES=2: lhs=0xFF, rhs=0x01, cin=0, sub=0, out_ready=1 -> io_out=0x00, io_cout=1, valid exactly 2 cycles after the input cycle; cross-chunk carry verified.
2. WIDTH=8, STAGES=2, sub=1: lhs=0x05, rhs=0x07, cin=0 -> io_out=0xFE, io_cout=0. Then lhs=0x07, rhs=0x05, cin=1 -> io_out=0x01, io_cout=1.
3. WIDTH=32, STAGES=4, out_ready=1: 8 back-to-back beats (i+0x10 + 0xFFFFFFF0) -> 8 consecutive result cycles with no gaps, in order; io_in_ready constantly 1.
4. Backpressure, WIDTH=8, STAGES=2, out_ready=0, three offered beats:
   - two accepted, then io_in_ready=0; output held stable ≥5 cycles.
   - release out_ready -> third beat accepted in the same cycle the first drains; all three results in order.
5. Async reset mid-flight: assert reset between clock edges with 2 beats in flight -> io_out_valid=0, io_out=0 immediately. After release, neither discarded beat appears; a new beat completes normally.
6. Randomised against golden model, WIDTH=16, STAGES=4: random operands, cin, sub, in_valid and out_ready -> every result matches (lhs ± rhs ± cin) mod 2^16 with correct io_cout; no drops or duplicates.
